// File: rtl/vec_pkg.sv
// Shared types and sizing for the vector register file write-back path.
// Holds the register-file geometry and the write-back source encoding used by the arbiter.
package vec_pkg;

  localparam int VEC_REGS   = 8;
  localparam int VEC_LANES  = 4;
  localparam int VEC_ELEM_W = 8;
  localparam int VEC_ADDR_W = 3;

  typedef logic [VEC_LANES-1:0][VEC_ELEM_W-1:0] vec_t;
  typedef logic [VEC_ADDR_W-1:0]                regidx_t;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_MEM = 1'b1
  } wb_src_e;

endpackage

// File: rtl/vec_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter (ALU vs load unit); grant is combinational from the requests.
// Zero latency; a requester left ungranted simply waits, and last_grant only moves on a real transfer.
module rr_arb2
  import vec_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req_alu,
  input  logic req_mem,
  input  logic xfer,
  output logic gnt_alu,
  output logic gnt_mem
);

  wb_src_e last_grant;

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_grant <= WB_MEM;
    end else if (xfer) begin
      last_grant <= gnt_alu ? WB_ALU : WB_MEM;
    end
  end

  // Grants are held low while reset is asserted so no producer sees a phantom handshake.
  always_comb begin
    gnt_alu = 1'b0;
    gnt_mem = 1'b0;
    if (reset) begin
      if (req_alu && req_mem) begin
        gnt_alu = (last_grant == WB_MEM);
        gnt_mem = (last_grant == WB_ALU);
      end else begin
        gnt_alu = req_alu;
        gnt_mem = req_mem;
      end
    end
  end

endmodule

// File: rtl/vec_wb_arbiter.sv
// Vector register-file write-back controller with busy scoreboard; optional VEC_WB_CHECK_EN flags unreserved writes.
// One-cycle registered write stage, one transfer per cycle; producers stall via valid/ready, issue via issueStall.
module vec_wb_arbiter
  import vec_pkg::*;
#(
  parameter  int REGS   = VEC_REGS,
  parameter  int LANES  = VEC_LANES,
  parameter  int ELEM_W = VEC_ELEM_W,
  localparam int ADDR_W = $clog2(REGS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    issueValid,
  input  logic [ADDR_W-1:0]       issueDst,
  input  logic [ADDR_W-1:0]       issueSrc1,
  input  logic [ADDR_W-1:0]       issueSrc2,
  output logic                    issueStall,
  input  logic                    aluValid,
  input  logic [ADDR_W-1:0]       aluDst,
  input  logic [LANES*ELEM_W-1:0] aluData,
  output logic                    aluReady,
  input  logic                    memValid,
  input  logic [ADDR_W-1:0]       memDst,
  input  logic [LANES*ELEM_W-1:0] memData,
  output logic                    memReady,
  output logic                    regWrEn,
  output logic [ADDR_W-1:0]       regToWrite,
  output logic [LANES*ELEM_W-1:0] regWriteData,
  output logic [REGS-1:0]         busyMask,
  output logic                    wbErr
);

  logic [REGS-1:0]         busy;
  logic [REGS-1:0]         busy_nxt;
  logic                    issue_acc;
  logic                    xfer;
  logic [ADDR_W-1:0]       wr_dst;
  logic [LANES*ELEM_W-1:0] wr_dat;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req_alu (aluValid),
    .req_mem (memValid),
    .xfer    (xfer),
    .gnt_alu (aluReady),
    .gnt_mem (memReady)
  );

  assign xfer   = (aluValid & aluReady) | (memValid & memReady);
  assign wr_dst = aluReady ? aluDst  : memDst;
  assign wr_dat = aluReady ? aluData : memData;

  assign issueStall = busy[issueDst] | busy[issueSrc1] | busy[issueSrc2];
  assign issue_acc  = issueValid & ~issueStall;
  assign busyMask   = busy;

  // Clear on the register-file write edge, then set, so a same-edge reservation wins.
  always_comb begin
    busy_nxt = busy;
    if (regWrEn) begin
      busy_nxt[regToWrite] = 1'b0;
    end
    if (issue_acc) begin
      busy_nxt[issueDst] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      busy         <= '0;
      regWrEn      <= 1'b0;
      regToWrite   <= '0;
      regWriteData <= '0;
    end else begin
      busy    <= busy_nxt;
      regWrEn <= xfer;
      if (xfer) begin
        regToWrite   <= wr_dst;
        regWriteData <= wr_dat;
      end
    end
  end

`ifdef VEC_WB_CHECK_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      wbErr <= 1'b0;
    end else if (xfer && !busy[wr_dst]) begin
      wbErr <= 1'b1;
    end
  end
`else
  assign wbErr = 1'b0;
`endif

endmodule

// File: doc/vec_wb_arbiter.md
Name: vec_wb_arbiter

Overview:
Write-back controller for the vector register file (8 regs x 4 lanes x 8 bits).
- Shares the file's single write port between two producers: the vector ALU and the memory-load unit.
- Keeps a per-register busy scoreboard so the issue stage stalls on RAW/WAW hazards until the register file holds the new value.
- Drives the register file write port (regWrEn, regToWrite, regWriteData) from a registered output stage.

Parameters:
REGS, 8, number of vector registers
LANES, 4, elements per vector
ELEM_W, 8, bits per element
ADDR_W, $clog2(REGS), register index width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low; sampled on clk
issueValid  in  1  issue stage presents an instruction
issueDst  in  ADDR_W  destination register to reserve
issueSrc1  in  ADDR_W  first source register
issueSrc2  in  ADDR_W  second source register
issueStall  out  1  combinational: 1 if any of Dst/Src1/Src2 is busy
aluValid  in  1  ALU result available
aluDst  in  ADDR_W  ALU destination
aluData  in  LANES*ELEM_W  ALU result vector
aluReady  out  1  ALU result granted this cycle
memValid  in  1  load result available
memDst  in  ADDR_W  load destination
memData  in  LANES*ELEM_W  load vector
memReady  out  1  load result granted this cycle
regWrEn  out  1  register file write enable
regToWrite  out  ADDR_W  register file write index
regWriteData  out  LANES*ELEM_W  register file write data
busyMask  out  REGS  scoreboard, bit i = register i has a pending write
wbErr  out  1  sticky error flag (see Optional Feature)

Behaviour:
- Reset (reset==0 at an edge): regWrEn=0, regToWrite=0, regWriteData=0, busyMask=0, wbErr=0, lastGrant=MEM (ALU has priority first).
  - aluReady and memReady are forced to 0 while reset is low.
  - Reset mid-transfer drops any registered write and all reservations.
- Issue:
  - issueStall = busy[issueDst] | busy[issueSrc1] | busy[issueSrc2], regardless of issueValid.
  - Accept = issueValid & ~issueStall. On accept, busy[issueDst] is set at that edge.
- Arbitration (combinational grant, round-robin, 2 requesters):
  - Only one valid: that source is granted.
  - Both valid: grant the source that is not lastGrant.
  - Neither valid: no grant.
  - aluReady/memReady equal the grant; a transfer occurs when valid & ready.
  - lastGrant updates only on a transfer.
  - Producers hold valid/Dst/Data stable until ready; valid is never withdrawn.
- Write stage (1-cycle latency):
  - Transfer at edge E loads regWrEn=1, regToWrite=Dst, regWriteData=Data, visible in the cycle after E.
  - With no transfer, regWrEn=0 in the next cycle; regToWrite and regWriteData hold their values.
  - The register file writes at edge E+1.
- Scoreboard clear:
  - busy[regToWrite] clears at edge E+1, the same edge as the register file write.
  - The cycle after E+1 therefore sees issueStall low and the new data on combinational reads.
- Simultaneous set and clear of the same bit: set wins (not reachable through legal issue, since a busy Dst stalls).
- Back-to-back: one transfer per cycle sustained. Both requesters continuously valid alternate ALU, MEM, ALU, ...
- Width rules: Dst is always < REGS (ADDR_W exact); lane 0 is the least-significant ELEM_W bits of the data.

Optional Feature:
Macro VEC_WB_CHECK_EN.
- Defined: wbErr sets (sticky until reset) when a transfer targets a register whose busy bit is 0 at the transfer edge. The write still proceeds.
- Undefined: wbErr is tied to 0 and no check logic is built.

Decomposition:
- Package vec_pkg:
  - constants VEC_REGS=8, VEC_LANES=4, VEC_ELEM_W=8, VEC_ADDR_W=3
  - typedef vec_t = logic [VEC_LANES-1:0][VEC_ELEM_W-1:0]
  - typedef regidx_t
  - enum wb_src_e {WB_ALU, WB_MEM}
- One natural sub-module: rr_arb2 (2-way round-robin arbiter holding lastGrant, enable = transfer).

Test Plan:
- Reset, then issue Dst=1 Src=0,0 -> busyMask=8'h02. ALU Dst=1 Data=32'hDEADBEEF -> regWrEn=1 with regToWrite=1, data DEADBEEF one cycle after transfer. busyMask=0 the cycle after that; regfile port reads lanes DE/AD/BE/EF.
- Hazard: reserve r7, then issue Src1=7 -> issueStall=1 until the cycle after mem writes r7 (Data=32'h1A2B3C4D). Then the issue is accepted.
- Contention: aluValid=memValid=1 for 4 cycles, Dst 2/3 -> grants ALU, MEM, ALU, MEM. regWrEn high 4 consecutive cycles; busy bits clear in order.
- Mid-operation reset: transfer at E, reset=0 sampled at E+1 -> regWrEn=0 and busyMask=0 after E+1. Ready stays 0 during reset; the first grant after reset goes to ALU.
- With VEC_WB_CHECK_EN: mem writes unreserved r5 -> wbErr=1 and stays 1 until reset, and r5 is still written. Without the macro, wbErr=0.
- Idle: no valids for 10 cycles -> regWrEn=0, regToWrite/regWriteData unchanged, no busy change.
